// File: rtl/spi_pkg.sv
// Shared definitions for the SPI initiator.
//   SPI_BITS     : bits per SPI byte
//   spi_state_e  : initiator FSM states
//   spi_timed    : 1 for states whose duration is set by the half-period timer
package spi_pkg;

  localparam int SPI_BITS = 8;

  typedef enum logic [2:0] {
    IDLE,
    LEAD,
    SCLK_HI,
    SCLK_LO,
    HOLD,
    TRAIL
  } spi_state_e;

  // IDLE and HOLD wait on the host; every other state lasts one half-period.
  function automatic logic spi_timed(spi_state_e s);
    return (s != IDLE) && (s != HOLD);
  endfunction

endpackage

// File: rtl/spi_half_period_timer.sv
// Half-period timer for the SPI initiator.
// Ports:
//   clk      : system clock
//   reset_n  : asynchronous active-low reset
//   load_i   : restart a half-period of CLK_DIV cycles (wins over count_i)
//   count_i  : decrement enable; low while the FSM waits on the host
//   expire_o : high in the last cycle of the half-period, so the FSM
//              changes phase on the edge that ends it
module spi_half_period_timer #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic load_i,
  input  logic count_i,
  output logic expire_o
);

  localparam int CNT_W = $clog2(CLK_DIV + 1);
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(CLK_DIV);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // The counter parks at zero once a half-period runs out without a reload,
  // so expire_o cannot fire again until the FSM asks for a new phase.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = LOAD_VAL;
    end else if (count_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - ONE;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = count_i && (cnt_q == ONE);

endmodule

// File: rtl/spi_initiator.sv
// SPI initiator, mode 0 (CPOL=0, CPHA=0), MSB first, one byte per accept.
// Consecutive bytes can share one chip-select window through HOLD.
// Ports:
//   clk, reset_n     : system clock, asynchronous active-low reset
//   start, tx_byte,
//   last             : byte request, taken when start & ready; last=1 deselects
//                      the target after this byte
//   release_i        : in HOLD, end the transaction without another byte
//                      (release is a reserved word in SystemVerilog)
//   ready, busy      : ready in IDLE/HOLD; busy whenever not IDLE
//   rx_byte, rx_valid: received byte and its one-cycle strobe
//   spi_cs_n, spi_sclk, spi_tx, spi_rx : SPI pins
module spi_initiator
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic [SPI_BITS-1:0] tx_byte,
  input  logic                last,
  input  logic                release_i,
  output logic                ready,
  output logic                busy,
  output logic [SPI_BITS-1:0] rx_byte,
  output logic                rx_valid,
  output logic                spi_cs_n,
  output logic                spi_sclk,
  output logic                spi_tx,
  input  logic                spi_rx
);

  localparam int BIT_CNT_W = $clog2(SPI_BITS + 1);
  localparam logic [BIT_CNT_W-1:0] BITS_DONE = BIT_CNT_W'(SPI_BITS);
  localparam logic [BIT_CNT_W-1:0] BIT_ONE   = BIT_CNT_W'(1);

  spi_state_e            state_q, state_d;
  logic [BIT_CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [SPI_BITS-1:0]   tx_sr_q, tx_sr_d;
  logic [SPI_BITS-1:0]   rx_sr_q, rx_sr_d;
  logic [SPI_BITS-1:0]   rx_byte_q, rx_byte_d;
  logic                  last_q, last_d;
  logic                  rx_valid_q, rx_valid_d;
  logic                  cs_n_q, cs_n_d;
  logic                  sclk_q, sclk_d;
  logic                  tx_q, tx_d;

  logic                  accept;
  logic                  tmr_load;
  logic                  tmr_expire;

  spi_half_period_timer #(
    .CLK_DIV (CLK_DIV)
  ) u_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .load_i   (tmr_load),
    .count_i  (spi_timed(state_q)),
    .expire_o (tmr_expire)
  );

  assign ready  = (state_q == IDLE) || (state_q == HOLD);
  assign busy   = (state_q != IDLE);
  assign accept = start && ready;

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    tx_sr_d    = tx_sr_q;
    rx_sr_d    = rx_sr_q;
    rx_byte_d  = rx_byte_q;
    last_d     = last_q;
    rx_valid_d = 1'b0;
    cs_n_d     = cs_n_q;
    sclk_d     = sclk_q;
    tx_d       = tx_q;
    tmr_load   = 1'b0;

    unique case (state_q)
      IDLE, HOLD: begin
        // start beats release when both arrive in HOLD.
        if (accept) begin
          tx_d      = tx_byte[SPI_BITS-1];
          tx_sr_d   = {tx_byte[SPI_BITS-2:0], 1'b0};
          last_d    = last;
          bit_cnt_d = '0;
          cs_n_d    = 1'b0;
          tmr_load  = 1'b1;
          state_d   = LEAD;
        end else if ((state_q == HOLD) && release_i) begin
          cs_n_d   = 1'b1;
          tx_d     = 1'b0;
          tmr_load = 1'b1;
          state_d  = TRAIL;
        end
      end

      LEAD, SCLK_LO: begin
        if (tmr_expire) begin
          sclk_d    = 1'b1;
          rx_sr_d   = {rx_sr_q[SPI_BITS-2:0], spi_rx};
          bit_cnt_d = bit_cnt_q + BIT_ONE;
          tmr_load  = 1'b1;
          state_d   = SCLK_HI;
        end
      end

      SCLK_HI: begin
        if (tmr_expire) begin
          sclk_d = 1'b0;
          if (bit_cnt_q != BITS_DONE) begin
            tx_d     = tx_sr_q[SPI_BITS-1];
            tx_sr_d  = {tx_sr_q[SPI_BITS-2:0], 1'b0};
            tmr_load = 1'b1;
            state_d  = SCLK_LO;
          end else begin
            // Byte complete. spi_tx keeps bit 0 if the select is held open.
            rx_byte_d  = rx_sr_q;
            rx_valid_d = 1'b1;
            if (last_q) begin
              cs_n_d   = 1'b1;
              tx_d     = 1'b0;
              tmr_load = 1'b1;
              state_d  = TRAIL;
            end else begin
              state_d = HOLD;
            end
          end
        end
      end

      TRAIL: begin
        if (tmr_expire) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      tx_sr_q    <= '0;
      rx_sr_q    <= '0;
      rx_byte_q  <= '0;
      last_q     <= 1'b0;
      rx_valid_q <= 1'b0;
      cs_n_q     <= 1'b1;
      sclk_q     <= 1'b0;
      tx_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      tx_sr_q    <= tx_sr_d;
      rx_sr_q    <= rx_sr_d;
      rx_byte_q  <= rx_byte_d;
      last_q     <= last_d;
      rx_valid_q <= rx_valid_d;
      cs_n_q     <= cs_n_d;
      sclk_q     <= sclk_d;
      tx_q       <= tx_d;
    end
  end

  // Pins come straight from flops.
  assign spi_cs_n = cs_n_q;
  assign spi_sclk = sclk_q;
  assign spi_tx   = tx_q;
  assign rx_byte  = rx_byte_q;
  assign rx_valid = rx_valid_q;

endmodule
